// File: rtl/ext_pkg.sv
// ext_pkg: shared mode constants, mode type and prefix state encodings for imm_extend_unit
package ext_pkg;
    typedef logic [1:0] ext_mode_t;
    localparam ext_mode_t EXT_ZERO      = 2'd0;
    localparam ext_mode_t EXT_SIGN      = 2'd1;
    localparam ext_mode_t EXT_UPPER     = 2'd2;
    localparam ext_mode_t EXT_SIGN_SHL2 = 2'd3;
    typedef enum logic {
        PFX_NONE = 1'b0,
        PFX_PEND = 1'b1
    } pfx_state_t;
endpackage

// File: rtl/imm_extend_unit_if.sv
// imm_extend_unit_if: handshake/bus bundle of imm_extend_unit; prefix signals exist only with EXT_PREFIX_EN
interface imm_extend_unit_if
    import ext_pkg::*;
#(
    parameter int IMM_W  = 16,
    parameter int DATA_W = 32
);
    localparam int PFX_W = DATA_W - IMM_W;
    logic              in_valid;
    logic              in_ready;
    logic [IMM_W-1:0]  imm;
    ext_mode_t         mode;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
`ifdef EXT_PREFIX_EN
    logic              pfx_ld;
    logic [PFX_W-1:0]  pfx_data;
    logic              pfx_pending;
    modport master (
        output in_valid, imm, mode, out_ready, pfx_ld, pfx_data,
        input  in_ready, out_valid, out_data, pfx_pending
    );
    modport slave (
        input  in_valid, imm, mode, out_ready, pfx_ld, pfx_data,
        output in_ready, out_valid, out_data, pfx_pending
    );
`else
    modport master (
        output in_valid, imm, mode, out_ready,
        input  in_ready, out_valid, out_data
    );
    modport slave (
        input  in_valid, imm, mode, out_ready,
        output in_ready, out_valid, out_data
    );
`endif
endinterface

// File: rtl/imm_extend_unit_ext_core.sv
// ext_core: combinational mode/prefix mux producing the next extended immediate
module ext_core
    import ext_pkg::*;
#(
    parameter int IMM_W  = 16,
    parameter int DATA_W = 32
) (
    input  logic [IMM_W-1:0]        imm,
    input  ext_mode_t               mode,
    input  logic                    pend,
    input  logic [DATA_W-IMM_W-1:0] prefix,
    output logic [DATA_W-1:0]       res
);
    localparam int PFX_W = DATA_W - IMM_W;
    logic [DATA_W-1:0] base;
    // base is the prefixed value when a prefix is pending, else the sign extension
    always_comb begin
        base = pend ? {prefix, imm} : {{PFX_W{imm[IMM_W-1]}}, imm};
        res  = mode == EXT_UPPER     ? {imm, {PFX_W{1'b0}}} :
               mode == EXT_SIGN_SHL2 ? base << 2 :
               (mode == EXT_SIGN || pend) ? base : {{PFX_W{1'b0}}, imm};
    end
endmodule

// File: rtl/imm_extend_unit.sv
// imm_extend_unit: registered immediate extender with valid/ready handshake; optional prefix under EXT_PREFIX_EN
module imm_extend_unit
    import ext_pkg::*;
#(
    parameter int IMM_W  = 16,
    parameter int DATA_W = 32
) (
    input logic clk,
    input logic rst,
    imm_extend_unit_if.slave bus
);
    localparam int PFX_W = DATA_W - IMM_W;
    logic              acc;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [DATA_W-1:0] core_res;
    logic              pend;
    logic [PFX_W-1:0]  prefix;
    ext_core #(.IMM_W(IMM_W), .DATA_W(DATA_W)) u_core (
        .imm    (bus.imm),
        .mode   (bus.mode),
        .pend   (pend),
        .prefix (prefix),
        .res    (core_res)
    );
    assign bus.in_ready  = !out_valid_q || bus.out_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    // one-entry output register: load on accept, drop on take, hold otherwise
    always_comb begin
        acc         = bus.in_valid && bus.in_ready;
        out_valid_d = acc ? 1'b1 : bus.out_ready ? 1'b0 : out_valid_q;
        out_data_d  = acc ? core_res : out_data_q;
    end
    // output register update
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end
`ifdef EXT_PREFIX_EN
    pfx_state_t       pfx_state_q, pfx_state_d;
    logic [PFX_W-1:0] pfx_q, pfx_d;
    // a load always wins (new prefix pends); otherwise an accepted input consumes the prefix
    always_comb begin
        pfx_state_d = bus.pfx_ld ? PFX_PEND : acc ? PFX_NONE : pfx_state_q;
        pfx_d       = bus.pfx_ld ? bus.pfx_data : pfx_q;
    end
    // prefix state and register
    always_ff @(posedge clk) begin
        if (rst) begin
            pfx_state_q <= PFX_NONE;
            pfx_q       <= '0;
        end else begin
            pfx_state_q <= pfx_state_d;
            pfx_q       <= pfx_d;
        end
    end
    assign pend            = pfx_state_q == PFX_PEND;
    assign prefix          = pfx_q;
    assign bus.pfx_pending = pend;
`else
    assign pend   = 1'b0;
    assign prefix = '0;
`endif
endmodule

// File: tb/tb_imm_extend_unit.sv
// tb_imm_extend_unit: directed vectors plus a per-cycle arithmetic reference model; prefix tests need EXT_PREFIX_EN
module tb_imm_extend_unit;
    logic        clk;
    logic        rst;
    logic        ld;
    logic [15:0] pd;
    int          checks;
    int          errors;
    logic        started;
    logic        ev;
    logic [31:0] ed;
    logic        ep;
    logic [15:0] epf;

    imm_extend_unit_if #(.IMM_W(16), .DATA_W(32)) bus ();
    imm_extend_unit #(.IMM_W(16), .DATA_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

`ifdef EXT_PREFIX_EN
    assign bus.pfx_ld   = ld;
    assign bus.pfx_data = pd;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] g, input logic [31:0] e);
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", n, g, e, $time);
        end
    endtask

    // value of the extended immediate computed with plain integer arithmetic
    function automatic logic [31:0] expect_val(input logic [1:0] m, input logic [15:0] v,
                                               input logic p, input logic [15:0] pf);
        longint s;
        s = p ? longint'(pf) * 65536 + longint'(v)
              : (v >= 16'h8000 ? longint'(v) - 65536 : longint'(v));
        case (m)
            2'd0:    s = p ? s : longint'(v);
            2'd1:    s = s;
            2'd2:    s = longint'(v) * 65536;
            default: s = s * 4;
        endcase
        return s[31:0];
    endfunction

    // reference model advanced on every rising edge
    always @(posedge clk) begin
        if (rst) begin
            ev      <= 1'b0;
            ed      <= '0;
            ep      <= 1'b0;
            epf     <= '0;
            started <= 1'b1;
        end else begin
            if (bus.in_valid && (!ev || bus.out_ready)) begin
                ev <= 1'b1;
                ed <= expect_val(bus.mode, bus.imm, ep, epf);
            end else if (bus.out_ready) begin
                ev <= 1'b0;
            end
            if (ld) begin
                ep  <= 1'b1;
                epf <= pd;
            end else if (bus.in_valid && (!ev || bus.out_ready)) begin
                ep <= 1'b0;
            end
        end
    end

    // compare DUT against the model every cycle on the falling edge
    always @(negedge clk) begin
        if (started) begin
            chk("cmp_out_valid", {31'b0, bus.out_valid}, {31'b0, ev});
            chk("cmp_out_data", bus.out_data, ed);
            chk("cmp_in_ready", {31'b0, bus.in_ready}, {31'b0, (!ev || bus.out_ready)});
`ifdef EXT_PREFIX_EN
            chk("cmp_pfx_pending", {31'b0, bus.pfx_pending}, {31'b0, ep});
`endif
        end
    end

    task automatic send(input logic [1:0] m, input logic [15:0] v);
        bus.mode     = m;
        bus.imm      = v;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #2;
        bus.in_valid = 1'b0;
        ld           = 1'b0;
    endtask

    task automatic load(input logic [15:0] v);
        ld = 1'b1;
        pd = v;
        @(posedge clk);
        #2;
        ld = 1'b0;
    endtask

    logic [1:0]  vm [9] = '{2'd1, 2'd0, 2'd2, 2'd3, 2'd1, 2'd3, 2'd3, 2'd0, 2'd2};
    logic [15:0] vi [9] = '{16'h8001, 16'h8001, 16'h1234, 16'hFFFF, 16'h7FFF,
                            16'h4001, 16'h8000, 16'h0000, 16'hFFFF};
    logic [31:0] vx [9] = '{32'hFFFF8001, 32'h00008001, 32'h12340000, 32'hFFFFFFFC,
                            32'h00007FFF, 32'h00010004, 32'hFFFE0000, 32'h00000000,
                            32'hFFFF0000};

    initial begin
        checks        = 0;
        errors        = 0;
        started       = 1'b0;
        ev            = 1'b0;
        ed            = '0;
        ep            = 1'b0;
        epf           = '0;
        rst           = 1'b1;
        ld            = 1'b0;
        pd            = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.imm       = '0;
        bus.mode      = 2'd0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        chk("reset_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("reset_out_data", bus.out_data, 32'd0);
        chk("reset_in_ready", {31'b0, bus.in_ready}, 32'd1);
`ifdef EXT_PREFIX_EN
        chk("reset_pfx_pending", {31'b0, bus.pfx_pending}, 32'd0);
`endif
        for (int i = 0; i < 9; i++) begin
            send(vm[i], vi[i]);
            chk("vec_out_valid", {31'b0, bus.out_valid}, 32'd1);
            chk("vec_out_data", bus.out_data, vx[i]);
        end
`ifdef EXT_PREFIX_EN
        load(16'hABCD);
        chk("pfx_pending_set", {31'b0, bus.pfx_pending}, 32'd1);
        send(2'd0, 16'h0042);
        chk("pfx_zero", bus.out_data, 32'hABCD0042);
        chk("pfx_consumed", {31'b0, bus.pfx_pending}, 32'd0);
        send(2'd1, 16'h8000);
        chk("after_pfx_sign", bus.out_data, 32'hFFFF8000);
        ld = 1'b1;
        pd = 16'h1111;
        send(2'd0, 16'h0005);
        chk("same_cycle_old_state", bus.out_data, 32'h00000005);
        chk("same_cycle_pending", {31'b0, bus.pfx_pending}, 32'd1);
        send(2'd0, 16'h0006);
        chk("same_cycle_new_pfx", bus.out_data, 32'h11110006);
        load(16'h0001);
        send(2'd3, 16'h8003);
        chk("pfx_shl2", bus.out_data, 32'h0006000C);
        load(16'hBEEF);
        send(2'd2, 16'h00AB);
        chk("pfx_upper", bus.out_data, 32'h00AB0000);
        chk("pfx_upper_consumed", {31'b0, bus.pfx_pending}, 32'd0);
        load(16'h2222);
        load(16'h3333);
        send(2'd0, 16'h0001);
        chk("pfx_overwrite", bus.out_data, 32'h33330001);
`endif
        @(posedge clk);
        #2;
        bus.out_ready = 1'b0;
        send(2'd0, 16'h0077);
        chk("bp_first", bus.out_data, 32'h00000077);
        bus.mode     = 2'd0;
        bus.imm      = 16'h0088;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #2;
            chk("bp_hold_data", bus.out_data, 32'h00000077);
            chk("bp_hold_valid", {31'b0, bus.out_valid}, 32'd1);
            chk("bp_in_ready_low", {31'b0, bus.in_ready}, 32'd0);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp_in_ready_high", {31'b0, bus.in_ready}, 32'd1);
        @(posedge clk);
        #2;
        bus.in_valid = 1'b0;
        chk("bp_take_accept", bus.out_data, 32'h00000088);
        chk("bp_take_valid", {31'b0, bus.out_valid}, 32'd1);
        bus.out_ready = 1'b0;
        ld = 1'b1;
        pd = 16'h5555;
        send(2'd0, 16'h0009);
        chk("pre_rst_valid", {31'b0, bus.out_valid}, 32'd1);
`ifdef EXT_PREFIX_EN
        chk("pre_rst_pending", {31'b0, bus.pfx_pending}, 32'd1);
`endif
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("rst_out_data", bus.out_data, 32'd0);
        chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
`ifdef EXT_PREFIX_EN
        chk("rst_pfx_pending", {31'b0, bus.pfx_pending}, 32'd0);
`endif
        send(2'd0, 16'h0001);
        chk("post_rst_zero", bus.out_data, 32'h00000001);
        repeat (3) @(posedge clk);
        #2;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
